des_key_schedule: RTL and testbench

- Sequential DES round-key generator that sits directly upstream of the per-round datapath.
- Accepts a 64-bit key and applies PC-1 once.
- Then emits one 48-bit subkey per accepted transfer (K1..K16 for encrypt, K16..K1 for decrypt) over a valid/ready handshake. Subkeys feed the 48-bit round-key input of the round stage.
- Only one CD register pair (56 bits) is stored; subkeys are generated on the fly rather than held as a 16-entry table.

---
 rtl/des_key_schedule.sv | 188 ++++++++++++++++++
 tb/tb_des_key_schedule.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Brief    : Sequential DES round-key generator. It holds one C/D pair and
//            emits K1..K16 (or K16..K1) over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule #(
    parameter int CHECK_PARITY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [63:0] i_key,
    input  logic        i_decrypt,
    output logic        o_busy,
    output logic [47:0] o_key,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [3:0]  o_round,
    output logic        o_last,
    output logic        o_parity_err
);

    // Tables hold FIPS 1-based bit numbers, first entry in the top field.
    localparam logic [335:0] PC1_TBL = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [287:0] PC2_TBL = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [335:0] tbl;
        logic [55:0]  res;
        tbl = PC1_TBL;
        res = '0;
        for (int j = 0; j < 56; j++) begin
            res = {res[54:0], key[6'(7'd64 - {1'b0, tbl[335:330]})]};
            tbl = tbl << 6;
        end
        return res;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [287:0] tbl;
        logic [47:0]  res;
        tbl = PC2_TBL;
        res = '0;
        for (int j = 0; j < 48; j++) begin
            res = {res[46:0], cd[6'(6'd56 - tbl[287:282])]};
            tbl = tbl << 6;
        end
        return res;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_cnt;
    logic        r_mode;
    logic        r_perr;

    logic        w_load;
    logic        w_hs;
    logic        w_step;
    logic [55:0] w_cd0;
    logic [4:0]  w_sched_idx;
    logic        w_two;
    logic [27:0] w_c_step;
    logic [27:0] w_d_step;
    logic [63:0] w_par_tmp;
    logic        w_perr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_hs         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (i_ready) begin
                    w_hs = 1'b1;
                    if (r_cnt == 4'd15) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_step = w_hs && (r_cnt != 4'd15);
    assign w_cd0  = pc1(i_key);

    // Shift-schedule entries 1, 2, 9 and 16 rotate by one; all others by two.
    always_comb begin
        w_sched_idx = r_mode ? (5'd16 - {1'b0, r_cnt}) : ({1'b0, r_cnt} + 5'd2);
        w_two       = !((w_sched_idx == 5'd1) || (w_sched_idx == 5'd2) ||
                        (w_sched_idx == 5'd9) || (w_sched_idx == 5'd16));
        w_c_step    = r_mode ? rotr(r_c, w_two) : rotl(r_c, w_two);
        w_d_step    = r_mode ? rotr(r_d, w_two) : rotl(r_d, w_two);
    end

    always_comb begin
        w_par_tmp = i_key;
        w_perr    = 1'b0;
        for (int b = 0; b < 8; b++) begin
            w_perr    = w_perr | ~(^w_par_tmp[7:0]);
            w_par_tmp = w_par_tmp >> 8;
        end
        if (CHECK_PARITY == 0) begin
            w_perr = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_c    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_perr <= 1'b0;
        end else if (w_load) begin
            // Encrypt folds the first left rotation into the load so K1 appears next cycle.
            r_c    <= i_decrypt ? w_cd0[55:28] : rotl(w_cd0[55:28], 1'b0);
            r_d    <= i_decrypt ? w_cd0[27:0]  : rotl(w_cd0[27:0], 1'b0);
            r_mode <= i_decrypt;
            r_cnt  <= '0;
            r_perr <= w_perr;
        end else if (w_step) begin
            r_c   <= w_c_step;
            r_d   <= w_d_step;
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_busy       = (r_state == S_RUN);
    assign o_valid      = (r_state == S_RUN);
    assign o_key        = pc2({r_c, r_d});
    assign o_round      = r_mode ? (4'd15 - r_cnt) : r_cnt;
    assign o_last       = o_valid && (r_cnt == 4'd15);
    assign o_parity_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Brief    : Self-checking bench for des_key_schedule against a table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic        ready = 1'b1;
    logic [63:0] key = '0;

    logic        busy, valid, last, perr;
    logic [47:0] okey;
    logic [3:0]  round;
    logic        busy0, valid0, last0, perr0;
    logic [47:0] okey0;
    logic [3:0]  round0;

    int          checks = 0;
    int          failures = 0;
    logic [47:0] obs_keys [16];

    always #5 clk = ~clk;

    des_key_schedule #(.CHECK_PARITY(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_key(key), .i_decrypt(decrypt),
        .o_busy(busy), .o_key(okey), .o_valid(valid), .i_ready(ready),
        .o_round(round), .o_last(last), .o_parity_err(perr)
    );

    des_key_schedule #(.CHECK_PARITY(0)) dut_np (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_key(key), .i_decrypt(decrypt),
        .o_busy(busy0), .o_key(okey0), .o_valid(valid0), .i_ready(ready),
        .o_round(round0), .o_last(last0), .o_parity_err(perr0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int key_bit(input logic [63:0] k, input int n);
        return int'((k >> (64 - n)) & 64'd1);
    endfunction

    // Subkey K<rnd> computed directly: PC-1, cumulative left rotation, PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int rnd);
        int          c0 [28];
        int          d0 [28];
        int          cd [56];
        int          s;
        logic [47:0] r;
        s = 0;
        r = '0;
        for (int j = 0; j < 28; j++) begin
            c0[j] = key_bit(k, PC1_T[j]);
            d0[j] = key_bit(k, PC1_T[j + 28]);
        end
        for (int i = 0; i < rnd; i++) s += SHIFTS[i];
        for (int j = 0; j < 28; j++) begin
            cd[j]      = c0[(j + s) % 28];
            cd[j + 28] = d0[(j + s) % 28];
        end
        for (int j = 0; j < 48; j++) r = {r[46:0], cd[PC2_T[j] - 1][0]};
        return r;
    endfunction

    function automatic logic ref_parity_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if ($countones(8'(k >> (8 * b))) % 2 == 0) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_round"}, round, 0);
        check({tag, "_key"}, okey, 0);
        check({tag, "_perr"}, perr, 0);
    endtask

    task automatic run_schedule(input logic [63:0] k, input logic dec, input int stall_at,
                                input int stall_len, input int poke_at, input int rst_at);
        logic [47:0] exp_key;
        int          exp_round;
        key     = k;
        decrypt = dec;
        start   = 1'b1;
        ready   = 1'b1;
        step();
        start   = 1'b0;
        key     = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
        check("busy_after_start", busy, 1);
        check("perr", perr, ref_parity_bad(k));
        check("perr_noparity", perr0, 0);
        for (int p = 0; p < 16; p++) begin
            exp_round = dec ? 15 - p : p;
            exp_key   = ref_subkey(k, exp_round + 1);
            obs_keys[p] = okey;
            check("valid", valid, 1);
            check("key", okey, exp_key);
            check("key_noparity", okey0, exp_key);
            check("round", round, 64'(exp_round));
            check("last", last, 64'(p == 15));
            if (p == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check_reset_values("async_rst");
                step();
                rst = 1'b0;
                check_reset_values("rst_hold");
                return;
            end
            if (p == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    ready = 1'b0;
                    step();
                    check("stall_valid", valid, 1);
                    check("stall_key", okey, exp_key);
                    check("stall_round", round, 64'(exp_round));
                end
            end
            ready = 1'b1;
            if (p == poke_at) begin
                start   = 1'b1;
                key     = ~k ^ {$urandom, $urandom};
                decrypt = ~dec;
            end
            step();
            start = 1'b0;
        end
        check("valid_end", valid, 0);
        check("busy_end", busy, 0);
        check("last_end", last, 0);
        if (poke_at == 15) begin
            step();
            check("idle_after_last_poke", busy, 0);
        end
    endtask

    initial begin
        logic [63:0] rk;
        rst = 1'b1;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();
        check_reset_values("post_reset_idle");

        run_schedule(64'h133457799BBCDFF1, 1'b0, -1, 0, -1, -1);
        check("vec_k1", obs_keys[0], 48'h1B02EFFC7072);
        check("vec_k2", obs_keys[1], 48'h79AED9DBC9E5);
        check("vec_k16", obs_keys[15], 48'hCB3D8B0E17F5);

        run_schedule(64'h133457799BBCDFF1, 1'b1, -1, 0, -1, -1);
        check("vec_dec_first", obs_keys[0], 48'hCB3D8B0E17F5);
        check("vec_dec_last", obs_keys[15], 48'h1B02EFFC7072);

        run_schedule(64'h133457799BBCDFF1, 1'b0, 4, 3, -1, -1);

        run_schedule(64'h0, 1'b0, -1, 0, -1, -1);
        check("zero_key_k5", obs_keys[5], 48'h0);

        run_schedule({$urandom, $urandom}, 1'b0, -1, 0, 7, -1);
        run_schedule({$urandom, $urandom}, 1'b1, -1, 0, 15, -1);

        rk = {$urandom, $urandom};
        rk[7:0] = 8'h00;
        run_schedule(rk, 1'b0, -1, 0, -1, 9);
        run_schedule({$urandom, $urandom}, 1'b0, -1, 0, -1, -1);

        for (int r = 0; r < 6; r++) begin
            run_schedule({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 16)) - 1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
